wlan_interleaver: RTL and testbench
===================================

Name: wlan_interleaver

Overview:
- Serial-in/serial-out block interleaver for the IEEE 802.11a OFDM transmitter, between the convolutional encoder/puncturer and the QAM mapper.
- Accepts one coded bit per clock, groups bits into OFDM symbols of NCBPS bits, and applies the standard two-step permutation.
- Emits each permuted symbol serially, one bit per clock.
- Double-buffered, so continuous streaming sustains 1 bit/clock with no gaps.

Parameters:
- NCBPS_MAX, 288, largest coded-bits-per-symbol; sets the size of each buffer bank.
- DEFAULT_RATE, 4'b1101, rate code loaded at reset (6 Mbps).

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  synchronous, active-low reset.
- iEN  in  1  input bit qualifier; iData is sampled on every edge where iEN=1.
- iRateEN  in  1  one-cycle strobe; latches iRate.
- iRate  in  4  802.11a RATE field code.
- iData  in  1  serial coded input bit.
- oData  out  1  serial interleaved output bit.
- oValid  out  1  high on every cycle oData carries an interleaved bit.

Behaviour:
- Reset values (iRst=0 at an edge): oData=0, oValid=0, rate register=DEFAULT_RATE, write/read counters=0, both bank-full flags cleared. Reset takes priority over everything; a mid-symbol reset discards partial and pending symbols.
- Rate decode (NBPSC/NCBPS):
  - 1101, 1111 -> 1/48
  - 0101, 0111 -> 2/96
  - 1001, 1011 -> 4/192
  - 0001, 0011 -> 6/288
  - Any other code -> 1/48.
- s = max(NBPSC/2, 1).
- iRateEN=1 latches iRate at that edge. It must only be asserted while the block is idle (no partial or pending symbol); a rate change otherwise applies from the next symbol boundary.
- Permutation for input bit index k (0..NCBPS-1) within a symbol:
  - i = (NCBPS/16)*(k mod 16) + floor(k/16)
  - j = s*floor(i/s) + (i + NCBPS - floor(16*i/NCBPS)) mod s
  - Output position j carries input bit k.
- Implementation: write bit k to address j of the active bank; read the completed bank sequentially from address 0. Compute write addresses incrementally (counters), without dividers.
- Two banks of NCBPS_MAX bits. On the edge capturing input bit NCBPS-1:
  - the bank is marked full;
  - writing switches to the other bank;
  - on the next edge oValid rises with output bit 0.
- Latency: the first output bit of a symbol appears 1 cycle after its last input bit was sampled.
- Output runs NCBPS consecutive cycles, then oValid falls unless the other bank is already full, in which case output continues seamlessly with no idle cycle.
- iEN=0 pauses writing; a partial symbol is held indefinitely. Output is unaffected by iEN.
- Write into a bank still being read cannot occur at 1 bit/clock. If it would (protocol violation), the incoming bit is dropped.
- When oValid=0, oData=0.

Optional Feature:
- Macro INTLV_SYMSTART_EN.
- Defined: adds output port oSymStart (1 bit, reset 0), high exactly on the cycle oData carries bit 0 of each output symbol.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package intlv_pkg: rate code constants, the NBPSC/NCBPS lookup function, NCBPS_MAX, and the counter width derived from it.
- One sub-module intlv_addr_gen: given NCBPS, s and write strobe, produces write address j incrementally; reset at each symbol start.

Test Plan:
- Rate 1101, single 1 at k=1, rest 0, 48 bits -> oValid high 48 cycles starting 1 cycle after the last input; only output position 3 is 1. Repeat with a 1 at k=16 -> output position 1.
- Rate 1001, 1 at k=1 -> output position 13 (k=0 -> position 0); 192-cycle burst.
- Rate 0001, 1 at k=1 -> output position 20; 288-cycle burst.
- Rate 1101, 384 random bits with iEN held high -> 384 contiguous oValid cycles (8 symbols, no gaps), bit-exact against the golden model.
- Assert reset after 30 bits of a symbol, then send a full fresh symbol -> no output until the new 48 bits are complete; prior data is never emitted.
- Invalid rate 0000 -> behaves as 48-bit BPSK; iEN low for 10 cycles mid-symbol -> output identical to the unpaused case, only delayed.

Source files
------------

// File: rtl/intlv_pkg.sv
// Shared definitions for the 802.11a block interleaver: RATE codes, the
// per-rate symbol geometry lookup and the counter width for one bank.
package intlv_pkg;

    localparam int NCBPS_MAX = 32'd288;
    localparam int CNT_W     = $clog2(NCBPS_MAX);

    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    // Symbol geometry: coded bits per symbol, NCBPS/16 and the rotation span s.
    typedef struct packed {
        logic [CNT_W-1:0] ncbps;
        logic [CNT_W-1:0] rows;
        logic [1:0]       s;
    } rate_cfg_t;

    // Maps a RATE code to its NBPSC-derived geometry; unknown codes fall back to BPSK.
    function automatic rate_cfg_t rate_decode(input logic [3:0] rate);
        rate_cfg_t  cfg;
        logic [2:0] nbpsc;
        case (rate)
            RATE_6,  RATE_9:  nbpsc = 3'd1;
            RATE_12, RATE_18: nbpsc = 3'd2;
            RATE_24, RATE_36: nbpsc = 3'd4;
            RATE_48, RATE_54: nbpsc = 3'd6;
            default:          nbpsc = 3'd1;
        endcase
        cfg.ncbps = {{(CNT_W-3){1'b0}}, nbpsc} * 9'd48;
        cfg.rows  = cfg.ncbps >> 4;
        // s = max(NBPSC/2, 1): only 16-QAM and 64-QAM exceed 1
        cfg.s     = (nbpsc > 3'd3) ? nbpsc[2:1] : 2'd1;
        return cfg;
    endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// Incremental write-address generator for the 802.11a interleaver.
// Input bit k is tracked as (row, col) = (k/16, k%16), so the first
// permutation index is i = col*rows + row and floor(16*i/NCBPS) == col.
// rows is a multiple of s for every rate, so i mod s == row mod s and the
// second permutation reduces to a small rotation inside each s-group.
module intlv_addr_gen
    import intlv_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst,
    input  logic [CNT_W-1:0] rows,
    input  logic [1:0]       s,
    input  logic             advance,
    input  logic             clear,
    output logic [CNT_W-1:0] addr
);

    logic [3:0]       col_r;
    logic [CNT_W-1:0] row_r;
    logic [CNT_W-1:0] base_r;      // col_r * rows
    logic [1:0]       row_mod_r;   // row_r mod s
    logic [1:0]       col_mod_r;   // col_r mod s
    logic [CNT_W-1:0] i_s;
    logic [2:0]       diff_s;
    logic [2:0]       rot_s;

    function automatic logic [1:0] mod_inc(input logic [1:0] v, input logic [1:0] m);
        logic [1:0] nxt;
        nxt = v + 2'd1;
        return (nxt == m) ? 2'd0 : nxt;
    endfunction

    // Permuted address from the current (row, col) position.
    always_comb begin
        i_s    = base_r + row_r;
        diff_s = {1'b0, row_mod_r} + {1'b0, s} - {1'b0, col_mod_r};
        if (diff_s >= {1'b0, s}) begin
            rot_s = diff_s - {1'b0, s};
        end else begin
            rot_s = diff_s;
        end
        addr = i_s - {{(CNT_W-2){1'b0}}, row_mod_r} + {{(CNT_W-3){1'b0}}, rot_s};
    end

    // Step (row, col) and their running products/residues once per accepted bit.
    always_ff @(posedge iClk) begin
        if (!iRst || clear) begin
            col_r     <= 4'd0;
            row_r     <= {CNT_W{1'b0}};
            base_r    <= {CNT_W{1'b0}};
            row_mod_r <= 2'd0;
            col_mod_r <= 2'd0;
        end else if (advance) begin
            if (col_r == 4'd15) begin
                col_r     <= 4'd0;
                base_r    <= {CNT_W{1'b0}};
                col_mod_r <= 2'd0;
                row_r     <= row_r + 1'b1;
                row_mod_r <= mod_inc(row_mod_r, s);
            end else begin
                col_r     <= col_r + 1'b1;
                base_r    <= base_r + rows;
                col_mod_r <= mod_inc(col_mod_r, s);
            end
        end
    end

endmodule

// File: rtl/wlan_interleaver.sv
// 802.11a OFDM block interleaver, serial in / serial out, double-buffered.
// Bits are written to their permuted address in one bank while the other
// bank is read out sequentially, sustaining one bit per clock.
// Optional macro INTLV_SYMSTART_EN adds oSymStart (marks output bit 0).
module wlan_interleaver #(
    parameter int         NCBPS_MAX    = 32'd288,
    parameter logic [3:0] DEFAULT_RATE = 4'b1101
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEN,
    input  logic       iRateEN,
    input  logic [3:0] iRate,
    input  logic       iData,
    output logic       oData,
    output logic       oValid
`ifdef INTLV_SYMSTART_EN
    ,
    output logic       oSymStart
`endif
);

    import intlv_pkg::*;

    logic [3:0]           rate_r;
    rate_cfg_t            wr_cfg_r;
    rate_cfg_t            cur_cfg_s;
    logic                 wr_bank_r;
    logic [CNT_W-1:0]     wr_cnt_r;
    logic [CNT_W-1:0]     wr_addr_s;
    logic                 wr_ok_s;
    logic                 wr_last_s;
    logic                 rd_bank_r;
    logic [CNT_W-1:0]     rd_cnt_r;
    logic                 rd_go_s;
    logic                 rd_last_s;
    logic [1:0]           full_r;
    logic [1:0]           full_set_s;
    logic [1:0]           full_clr_s;
    logic [CNT_W-1:0]     bank_len_r [2];
    logic [NCBPS_MAX-1:0] mem_r [2];

    // Geometry is sampled from the rate register only between symbols.
    always_comb begin
        cur_cfg_s  = (wr_cnt_r == {CNT_W{1'b0}}) ? rate_decode(rate_r) : wr_cfg_r;
        wr_ok_s    = iEN && !full_r[wr_bank_r];
        wr_last_s  = wr_ok_s && (wr_cnt_r == cur_cfg_s.ncbps - 1'b1);
        rd_go_s    = full_r[rd_bank_r];
        rd_last_s  = rd_go_s && (rd_cnt_r == bank_len_r[rd_bank_r] - 1'b1);
        full_set_s = wr_last_s ? (2'b01 << wr_bank_r) : 2'b00;
        full_clr_s = rd_last_s ? (2'b01 << rd_bank_r) : 2'b00;
    end

    intlv_addr_gen u_addr_gen (
        .iClk    (iClk),
        .iRst    (iRst),
        .rows    (cur_cfg_s.rows),
        .s       (cur_cfg_s.s),
        .advance (wr_ok_s),
        .clear   (wr_last_s),
        .addr    (wr_addr_s)
    );

    // RATE code register, loaded by the strobe.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            rate_r <= DEFAULT_RATE;
        end else if (iRateEN) begin
            rate_r <= iRate;
        end
    end

    // Holds the geometry of the symbol being written so a late rate change waits.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            wr_cfg_r <= rate_decode(DEFAULT_RATE);
        end else begin
            wr_cfg_r <= cur_cfg_s;
        end
    end

    // Input bit counter and write-bank select; a dropped bit does not advance.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            wr_cnt_r  <= {CNT_W{1'b0}};
            wr_bank_r <= 1'b0;
        end else if (wr_last_s) begin
            wr_cnt_r  <= {CNT_W{1'b0}};
            wr_bank_r <= ~wr_bank_r;
        end else if (wr_ok_s) begin
            wr_cnt_r  <= wr_cnt_r + 1'b1;
        end
    end

    // Bank storage: each accepted bit lands at its permuted address.
    always_ff @(posedge iClk) begin
        if (wr_ok_s) begin
            mem_r[wr_bank_r][wr_addr_s] <= iData;
        end
    end

    // Bank-full flags and the symbol length captured with each completed bank.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            full_r        <= 2'b00;
            bank_len_r[0] <= {CNT_W{1'b0}};
            bank_len_r[1] <= {CNT_W{1'b0}};
        end else begin
            full_r <= (full_r & ~full_clr_s) | full_set_s;
            if (wr_last_s) begin
                bank_len_r[wr_bank_r] <= cur_cfg_s.ncbps;
            end
        end
    end

    // Sequential readout; releasing a bank on its last bit lets the other
    // bank start on the very next edge without an idle cycle.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            oData     <= 1'b0;
            oValid    <= 1'b0;
            rd_cnt_r  <= {CNT_W{1'b0}};
            rd_bank_r <= 1'b0;
        end else if (rd_go_s) begin
            oValid <= 1'b1;
            oData  <= mem_r[rd_bank_r][rd_cnt_r];
            if (rd_last_s) begin
                rd_cnt_r  <= {CNT_W{1'b0}};
                rd_bank_r <= ~rd_bank_r;
            end else begin
                rd_cnt_r  <= rd_cnt_r + 1'b1;
            end
        end else begin
            oValid <= 1'b0;
            oData  <= 1'b0;
        end
    end

`ifdef INTLV_SYMSTART_EN
    // Flags the cycle that carries output bit 0 of a symbol.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            oSymStart <= 1'b0;
        end else begin
            oSymStart <= rd_go_s && (rd_cnt_r == {CNT_W{1'b0}});
        end
    end
`endif

endmodule

// File: tb/tb_wlan_interleaver.sv
// Directed bench for wlan_interleaver: hand-picked single-bit symbols per
// rate, a long random stream, mid-symbol reset and an input pause.
module tb_wlan_interleaver;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEN;
    logic       iRateEN;
    logic [3:0] iRate;
    logic       iData;
    logic       oData;
    logic       oValid;
`ifdef INTLV_SYMSTART_EN
    logic       oSymStart;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   fails = 0;
    int   idle_bad = 0;
    int   ss_bad = 0;
    int   first_in_cyc = 0;
    int   last_in_cyc = 0;
    logic in_bits [0:383];
    logic out_q [$];
    int   cyc_q [$];
    logic ss_q [$];

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    wlan_interleaver dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iEN       (iEN),
        .iRateEN   (iRateEN),
        .iRate     (iRate),
        .iData     (iData),
        .oData     (oData),
        .oValid    (oValid)
`ifdef INTLV_SYMSTART_EN
        ,
        .oSymStart (oSymStart)
`endif
    );

    // Output monitor, sampled mid-cycle.
    always @(negedge iClk) begin
        if (oValid === 1'b1) begin
            out_q.push_back(oData);
            cyc_q.push_back(cyc);
`ifdef INTLV_SYMSTART_EN
            ss_q.push_back(oSymStart);
`endif
        end else begin
            if (iRst === 1'b1 && oData !== 1'b0) idle_bad <= idle_bad + 1;
`ifdef INTLV_SYMSTART_EN
            if (oSymStart !== 1'b0) ss_bad <= ss_bad + 1;
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference permutation written straight from the 802.11a equations.
    function automatic int perm(input int k, input int n, input int s);
        int i;
        int j;
        i = (n / 16) * (k % 16) + k / 16;
        j = s * (i / s) + (i + n - (16 * i) / n) % s;
        return j;
    endfunction

    function automatic int ones_in_out();
        int c;
        c = 0;
        foreach (out_q[x]) if (out_q[x] === 1'b1) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_rate(input logic [3:0] r);
        iRateEN = 1'b1;
        iRate   = r;
        @(posedge iClk); #1;
        iRateEN = 1'b0;
    endtask

    task automatic send_bits(input int count, input int pause_at, input int pause_len);
        for (int k = 0; k < count; k++) begin
            if (k == pause_at) begin
                iEN   = 1'b0;
                iData = 1'b1;
                repeat (pause_len) begin @(posedge iClk); #1; end
            end
            iEN   = 1'b1;
            iData = in_bits[k];
            @(posedge iClk); #1;
            if (k == 0) first_in_cyc = cyc;
            last_in_cyc = cyc;
        end
        iEN   = 1'b0;
        iData = 1'b0;
    endtask

    task automatic clear_q();
        out_q.delete();
        cyc_q.delete();
        ss_q.delete();
    endtask

    task automatic fill_zero(input int n);
        for (int k = 0; k < n; k++) in_bits[k] = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) in_bits[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic check_burst(input string tag, input int n, input int s, input int nsym,
                               input int exp_first);
        int total;
        int guard;
        int mism;
        int ss_mism;
        int idx;
        total   = n * nsym;
        guard   = 0;
        mism    = 0;
        ss_mism = 0;
        while (out_q.size() < total && guard < total + 200) begin
            @(negedge iClk); #1;
            guard++;
        end
        repeat (10) begin @(negedge iClk); #1; end
        chk({tag, "_count"}, out_q.size(), total);
        if (out_q.size() >= total) begin
            chk({tag, "_first_cycle"}, cyc_q[0], exp_first);
            chk({tag, "_span"}, cyc_q[total-1] - cyc_q[0], total - 1);
            for (int m = 0; m < nsym; m++) begin
                for (int k = 0; k < n; k++) begin
                    idx = m * n + perm(k, n, s);
                    if (out_q[idx] !== in_bits[m * n + k]) mism++;
                end
            end
            for (int x = 0; x < total; x++) begin
                if (ss_q.size() > x && ss_q[x] !== ((x % n) == 0)) ss_mism++;
            end
        end else begin
            mism = total;
        end
        chk({tag, "_bits"}, mism, 0);
`ifdef INTLV_SYMSTART_EN
        chk({tag, "_symstart"}, ss_mism, 0);
`endif
    endtask

    initial begin
        iRst    = 1'b0;
        iEN     = 1'b0;
        iRateEN = 1'b0;
        iRate   = 4'b0000;
        iData   = 1'b0;
        repeat (3) begin @(posedge iClk); #1; end
        @(negedge iClk); #1;
        chk("reset_valid", int'(oValid), 0);
        chk("reset_data", int'(oData), 0);
        @(posedge iClk); #1;
        iRst = 1'b1;

        // BPSK at the reset-default rate, single 1 at k=1 -> position 3
        fill_zero(48);
        in_bits[1] = 1'b1;
        send_bits(48, -1, 0);
        check_burst("t1", 48, 1, 1, last_in_cyc + 1);
        chk("t1_pos3", int'(out_q[3]), 1);
        chk("t1_ones", ones_in_out(), 1);
        clear_q();

        // single 1 at k=16 -> position 1
        fill_zero(48);
        in_bits[16] = 1'b1;
        send_bits(48, -1, 0);
        check_burst("t2", 48, 1, 1, last_in_cyc + 1);
        chk("t2_pos1", int'(out_q[1]), 1);
        chk("t2_ones", ones_in_out(), 1);
        clear_q();

        // 16-QAM: k=0 -> 0, k=1 -> 13
        set_rate(4'b1001);
        fill_zero(192);
        in_bits[0] = 1'b1;
        in_bits[1] = 1'b1;
        send_bits(192, -1, 0);
        check_burst("t3", 192, 2, 1, last_in_cyc + 1);
        chk("t3_pos0", int'(out_q[0]), 1);
        chk("t3_pos13", int'(out_q[13]), 1);
        chk("t3_ones", ones_in_out(), 2);
        clear_q();

        // 64-QAM: k=1 -> 20
        set_rate(4'b0001);
        fill_zero(288);
        in_bits[1] = 1'b1;
        send_bits(288, -1, 0);
        check_burst("t4", 288, 3, 1, last_in_cyc + 1);
        chk("t4_pos20", int'(out_q[20]), 1);
        chk("t4_ones", ones_in_out(), 1);
        clear_q();

        // eight back-to-back BPSK symbols, random data
        set_rate(4'b1101);
        fill_rand(384);
        send_bits(384, -1, 0);
        check_burst("t5", 48, 1, 8, first_in_cyc + 48);
        clear_q();

        // reset after 30 bits; the partial symbol must never appear
        for (int k = 0; k < 30; k++) in_bits[k] = 1'b1;
        send_bits(30, -1, 0);
        iRst = 1'b0;
        repeat (2) begin @(posedge iClk); #1; end
        iRst = 1'b1;
        repeat (60) begin @(negedge iClk); #1; end
        chk("t6_no_stale", out_q.size(), 0);
        fill_rand(48);
        in_bits[0] = 1'b0;
        send_bits(48, -1, 0);
        check_burst("t6", 48, 1, 1, last_in_cyc + 1);
        clear_q();

        // unknown rate code -> BPSK, with a 10-cycle input pause mid-symbol
        set_rate(4'b0000);
        fill_rand(48);
        send_bits(48, 20, 10);
        chk("t7_pause_len", last_in_cyc - first_in_cyc, 57);
        check_burst("t7", 48, 1, 1, last_in_cyc + 1);
        clear_q();

        chk("idle_data_zero", idle_bad, 0);
`ifdef INTLV_SYMSTART_EN
        chk("idle_symstart_zero", ss_bad, 0);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
